// File: rtl/lorenz_pkg.sv
// Shared defaults, fixed-point constants and FSM state type for the Lorenz DDA integrator.
package lorenz_pkg;

  localparam int W_DEFAULT        = 27;
  localparam int F_DEFAULT        = 20;
  localparam int DT_SHIFT_DEFAULT = 8;

  localparam logic [W_DEFAULT-1:0] ONE = W_DEFAULT'(1) << F_DEFAULT;

  typedef enum logic [2:0] {
    StIdle,
    StMulA,
    StMulB,
    StMulC,
    StMulD,
    StUpdate
  } state_e;

endpackage

// File: rtl/fix_mult.sv
// Signed fixed-point multiply: full 2W-bit product, arithmetic shift by F, truncate to W bits.
module fix_mult
  import lorenz_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int F = F_DEFAULT
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;
  logic signed [2*W-1:0] full;
  logic        [W-F-1:0] unused_hi;
  logic        [F-1:0]   unused_lo;

  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {{W{b[W-1]}}, b};
  assign full  = a_ext * b_ext;

  // Taking bits [F+W-1:F] is the >>> F followed by truncation; no rounding.
  assign {unused_hi, p, unused_lo} = full;

endmodule

// File: rtl/lorenz_dda_integrator.sv
// One forward-Euler step of the Lorenz system per step edge, sharing a single fixed-point
// multiplier across four multiply states.
module lorenz_dda_integrator
  import lorenz_pkg::*;
#(
  parameter int W        = W_DEFAULT,
  parameter int F        = F_DEFAULT,
  parameter int DT_SHIFT = DT_SHIFT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [W-1:0] sigma,
  input  logic signed [W-1:0] rho,
  input  logic signed [W-1:0] beta,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] y0,
  input  logic signed [W-1:0] z0,
  input  logic                init,
  input  logic                step,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] z_out,
  output logic                busy,
  output logic                done,
  output logic [31:0]         step_count
);

  state_e state_q, state_d;

  logic prev_step_q;
  logic armed_q, armed_d;
  logic edge_q, edge_d;

  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] z_q, z_d;
  logic signed [W-1:0] dx_q, dx_d;
  logic signed [W-1:0] dy_q, dy_d;
  logic signed [W-1:0] dz_q, dz_d;
  logic signed [W-1:0] pxy_q, pxy_d;

  logic [31:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic signed [W-1:0] mul_a, mul_b, mul_p;
  logic signed [W-1:0] sum_pre;

  fix_mult #(
    .W(W),
    .F(F)
  ) u_fix_mult (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  // armed_q blocks a step edge until step has been seen low once after reset.
  assign armed_d = armed_q | ~step;
  assign edge_d  = step & ~prev_step_q & armed_q & ~init & (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    mul_a   = '0;
    mul_b   = '0;
    sum_pre = '0;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    dz_d    = dz_q;
    pxy_d   = pxy_q;
    count_d = count_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (edge_q) state_d = StMulA;
      end
      StMulA: begin
        mul_a   = sigma;
        mul_b   = y_q - x_q;
        dx_d    = mul_p >>> DT_SHIFT;
        state_d = StMulB;
      end
      StMulB: begin
        mul_a   = x_q;
        mul_b   = rho - z_q;
        sum_pre = mul_p - y_q;
        dy_d    = sum_pre >>> DT_SHIFT;
        state_d = StMulC;
      end
      StMulC: begin
        mul_a   = x_q;
        mul_b   = y_q;
        pxy_d   = mul_p;
        state_d = StMulD;
      end
      StMulD: begin
        mul_a   = beta;
        mul_b   = z_q;
        sum_pre = pxy_q - mul_p;
        dz_d    = sum_pre >>> DT_SHIFT;
        state_d = StUpdate;
      end
      StUpdate: begin
        x_d     = x_q + dx_q;
        y_d     = y_q + dy_q;
        z_d     = z_q + dz_q;
        count_d = count_q + 32'd1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // init overrides everything, including a commit that would land this cycle.
    if (init) begin
      state_d = StIdle;
      x_d     = x0;
      y_d     = y0;
      z_d     = z0;
      count_d = '0;
      done_d  = 1'b0;
    end
  end

  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      prev_step_q <= 1'b0;
      armed_q     <= 1'b0;
      edge_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      dz_q        <= '0;
      pxy_q       <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_step_q <= step;
      armed_q     <= armed_d;
      edge_q      <= edge_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      dz_q        <= dz_d;
      pxy_q       <= pxy_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign z_out      = z_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_lorenz_dda_integrator.sv
// Randomised self-checking bench for lorenz_dda_integrator against a plain-arithmetic Euler model.
module tb_lorenz_dda_integrator;

  localparam int W  = 27;
  localparam int F  = 20;
  localparam int DT = 8;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic signed [W-1:0] sigma, rho, beta, x0, y0, z0;
  logic signed [W-1:0] x_out, y_out, z_out;
  logic                init, step, busy, done;
  logic [31:0]         step_count;

  int     n_checks = 0;
  int     n_errors = 0;
  longint mx, my, mz, mcount, msig, mrho, mbeta, ix, iy, iz;

  always #5 clk = ~clk;

  lorenz_dda_integrator #(
    .W(W),
    .F(F),
    .DT_SHIFT(DT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sigma(sigma),
    .rho(rho),
    .beta(beta),
    .x0(x0),
    .y0(y0),
    .z0(z0),
    .init(init),
    .step(step),
    .x_out(x_out),
    .y_out(y_out),
    .z_out(z_out),
    .busy(busy),
    .done(done),
    .step_count(step_count)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Interpret the low W bits as a signed W-bit number.
  function automatic longint sx(input longint v);
    return (v <<< (64 - W)) >>> (64 - W);
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return sx((a * b) >>> F);
  endfunction

  // One Euler step of the reference, all four derivatives from the old state.
  task automatic model_step();
    longint dx, dy, dz;
    dx = fmul(msig, sx(my - mx)) >>> DT;
    dy = sx(fmul(mx, sx(mrho - mz)) - my) >>> DT;
    dz = sx(fmul(mx, my) - fmul(mbeta, mz)) >>> DT;
    mx = sx(mx + dx);
    my = sx(my + dy);
    mz = sx(mz + dz);
    mcount = (mcount + 1) & 64'hFFFF_FFFF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coeffs(input longint s, input longint r, input longint b);
    sigma = s[W-1:0];
    rho   = r[W-1:0];
    beta  = b[W-1:0];
    msig  = sx(s);
    mrho  = sx(r);
    mbeta = sx(b);
  endtask

  task automatic do_init(input longint a, input longint b, input longint c, input int cycles);
    x0   = a[W-1:0];
    y0   = b[W-1:0];
    z0   = c[W-1:0];
    init = 1'b1;
    repeat (cycles) tick();
    init = 1'b0;
    ix = sx(a); iy = sx(b); iz = sx(c);
    mx = ix; my = iy; mz = iz;
    mcount = 0;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_x"}, longint'(x_out), mx);
    check_val({tag, "_y"}, longint'(y_out), my);
    check_val({tag, "_z"}, longint'(z_out), mz);
    check_val({tag, "_cnt"}, longint'(step_count), mcount);
  endtask

  // Caller has step low; step is held high for `hold` cycles after the sampling edge.
  task automatic run_step(input string tag, input int hold);
    longint ox;
    int     lat, ndone;
    ox = mx;
    lat = -1;
    ndone = 0;
    model_step();
    step = 1'b1;
    tick();
    for (int i = 1; i <= 25; i++) begin
      if (i == hold) step = 1'b0;
      tick();
      if (i == 3) check_val({tag, "_busy"}, longint'(busy), 1);
      if (i == 5) check_val({tag, "_x_early"}, longint'(x_out), ox);
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    step = 1'b0;
    check_val({tag, "_latency"}, lat, 6);
    check_val({tag, "_ndone"}, ndone, 1);
    check_val({tag, "_idle"}, longint'(busy), 0);
    check_state(tag);
  endtask

  initial begin
    int ndone;
    init = 1'b0;
    step = 1'b0;
    set_coeffs(0, 0, 0);
    x0 = '0; y0 = '0; z0 = '0;
    mx = 0; my = 0; mz = 0; mcount = 0;

    // Reset state
    repeat (2) tick();
    check_state("rst");
    check_val("rst_busy", longint'(busy), 0);
    check_val("rst_done", longint'(done), 0);
    reset_n = 1'b1;
    tick();

    // Init load
    do_init(64'h0100000, 0, 0, 2);
    check_state("init");

    // Reference step from (1,0,0)
    set_coeffs(64'h0A00000, 64'h1C00000, 64'h02AAAAA);
    run_step("ref", 1);
    check_val("ref_x_const", longint'(x_out), 64'h00F6000);
    check_val("ref_y_const", longint'(y_out), 64'h001C000);
    check_val("ref_z_const", longint'(z_out), 0);

    // step held high gives exactly one step
    run_step("hold", 20);

    // Second edge while busy is dropped
    model_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    check_val("midbusy_ndone", ndone, 1);
    check_state("midbusy");

    // init during MUL_C aborts the step
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    init = 1'b1;
    tick();
    ndone = done ? 1 : 0;
    check_val("abort_busy", longint'(busy), 0);
    mx = ix; my = iy; mz = iz; mcount = 0;
    check_state("abort");
    init = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check_val("abort_ndone", ndone, 0);
    check_state("abort_after");

    // init and step edge sampled together: no step
    init = 1'b1;
    step = 1'b1;
    tick();
    init = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    step = 1'b0;
    tick();
    check_val("same_ndone", ndone, 0);
    check_state("same");

    // Overflow wrap
    set_coeffs(0, 64'h3FFFFFF, 0);
    do_init(64'h3FFFFFF, 0, 0, 1);
    run_step("wrap", 1);

    // Randomised trajectories
    for (int it = 0; it < 8; it++) begin
      set_coeffs(longint'($urandom), longint'($urandom), longint'($urandom));
      do_init(longint'($urandom), longint'($urandom), longint'($urandom), 1);
      tick();
      for (int s = 0; s < int'($urandom_range(1, 3)); s++)
        run_step($sformatf("rnd%0d_%0d", it, s), int'($urandom_range(1, 10)));
    end

    // Async reset mid-step, then step held high across release
    step = 1'b1;
    tick();
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    mx = 0; my = 0; mz = 0; mcount = 0;
    check_state("arst");
    check_val("arst_busy", longint'(busy), 0);
    check_val("arst_done", longint'(done), 0);
    tick();
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check_val("postrst_ndone", ndone, 0);
    check_state("postrst");
    step = 1'b0;
    tick();
    set_coeffs(64'h0A00000, 64'h1C00000, 64'h02AAAAA);
    do_init(64'h0100000, 64'h0080000, 64'h0040000, 1);
    run_step("postrst_step", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
